// File: rtl/jtcolmix_prio_n.sv
// rtl/jtcolmix_prio_n.sv - parametrised priority colour mixer with MMR, fold pipeline and one-pixel latency
module jtcolmix_prio_n #(
  parameter int LAYERS = 5,
  parameter int CW     = 8,
  parameter int PW     = 6,
  parameter int HW     = 3
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pxl_cen,
  input  logic                 cs,
  input  logic [4:0]           addr,
  input  logic [7:0]           din,
  input  logic [LAYERS*PW-1:0] pri_in,
  input  logic [LAYERS*CW-1:0] col_in,
  input  logic [1:0]           shd_in,
  input  logic [4:0]           ioctl_addr,
  output logic [7:0]           ioctl_din,
  output logic [CW+HW-1:0]     cout,
  output logic                 col_n,
  output logic                 brit,
  output logic [1:0]           shd_out
);

  localparam int OW  = CW + HW;
  localparam int STW = $clog2(LAYERS + 2);

  logic [7:0] mmr [32];

  // Per-layer registers beyond LAYERS and the 24..31 hole are never written,
  // so they stay at their reset value of zero and read back as zero.
  function automatic logic reg_ok(input logic [4:0] a);
    if (a < 5'd8)       return int'(a) < LAYERS;
    else if (a < 5'd16) return (int'(a) - 8) < LAYERS;
    else                return a < 5'd24;
  endfunction

  // MMR write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mmr[i] <= 8'd0;
    end else if (cs && reg_ok(addr)) begin
      mmr[addr] <= din;
    end
  end

  assign ioctl_din = mmr[ioctl_addr];

  logic tie, bken;
  assign tie  = mmr[22][0];
  assign bken = mmr[22][1];

  // Stage 0: transparency and effective priority of every layer at the pixel strobe
  logic [PW-1:0] pri_c [8];
  logic          tr_c  [8];
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pri_c[i] = '0;
      tr_c[i]  = 1'b0;
    end
    for (int i = 0; i < LAYERS; i++) begin
      tr_c[i]  = mmr[17][i] ? (col_in[i*CW +: CW] == '0) : (col_in[i*CW +: 4] == 4'd0);
      pri_c[i] = tr_c[i] ? '1 : (mmr[16][i] ? pri_in[i*PW +: PW] : mmr[i][PW-1:0]);
    end
  end

  logic [CW-1:0]  col_l [8];
  logic [PW-1:0]  pri_l [8];
  logic           tr_l  [8];
  logic [1:0]     shd_l;
  logic [STW-1:0] st;

  logic [OW-1:0]  best_col;
  logic [PW-1:0]  best_pri;
  logic           best_tr;

  logic [OW-1:0]  done_col;
  logic           done_tr, done_brt, done_sel;
  logic [1:0]     done_shd;

  // Candidate for the current fold step: layer st-1
  logic [2:0]     lidx;
  logic [OW-1:0]  cand_col;
  logic [PW-1:0]  cand_pri;
  logic           cand_tr;
  logic           take;
  logic [PW-1:0]  thr;
  always_comb begin
    lidx     = 3'(st - 1'b1);
    cand_col = {mmr[5'd8 + {2'b00, lidx}][HW-1:0], col_l[lidx]};
    cand_pri = pri_l[lidx];
    cand_tr  = tr_l[lidx];
    take     = (st == STW'(1)) || (tie ? (cand_pri <= best_pri) : (cand_pri < best_pri));
    thr      = (shd_l == 2'd0) ? '1 : mmr[5'd18 + {3'b000, shd_l}][PW-1:0];
  end

  // Pixel pipeline: strobe sample / fold / commit; the strobe always wins over commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= '0;
      shd_l    <= 2'd0;
      for (int i = 0; i < 8; i++) begin
        col_l[i] <= '0;
        pri_l[i] <= '0;
        tr_l[i]  <= 1'b0;
      end
      best_col <= '0;
      best_pri <= '0;
      best_tr  <= 1'b0;
      done_col <= '0;
      done_tr  <= 1'b0;
      done_brt <= 1'b0;
      done_sel <= 1'b0;
      done_shd <= 2'd0;
      cout     <= '0;
      col_n    <= 1'b0;
      brit     <= 1'b0;
      shd_out  <= 2'b11;
    end else if (pxl_cen) begin
      cout    <= done_col;
      col_n   <= done_tr;
      brit    <= done_brt;
      shd_out <= done_sel ? ~done_shd : 2'b11;
      shd_l   <= shd_in;
      for (int i = 0; i < LAYERS; i++) begin
        col_l[i] <= col_in[i*CW +: CW];
        pri_l[i] <= pri_c[i];
        tr_l[i]  <= tr_c[i];
      end
      st <= STW'(1);
    end else if (st != '0 && st <= STW'(LAYERS)) begin
      if (take) begin
        best_col <= cand_col;
        best_pri <= cand_pri;
        best_tr  <= cand_tr;
      end
      st <= st + 1'b1;
    end else if (st == STW'(LAYERS + 1)) begin
      done_col <= (best_tr && bken) ? OW'(mmr[23]) : best_col;
      done_tr  <= best_tr;
      done_brt <= best_pri >= mmr[18][PW-1:0];
      done_sel <= best_pri < thr;
      done_shd <= shd_l;
      st       <= '0;
    end
  end

endmodule

// File: doc/jtcolmix_prio_n.md
Name: jtcolmix_prio_n

Overview:
- Parametrised priority colour mixer for Konami-style multi-layer video: takes LAYERS tile/sprite colour indexes with per-layer priorities, selects the frontmost opaque layer, and emits a palette address, shadow code and bright flag.
- Sits between the layer generators and the palette RAM.
- Generalises the fixed 5-layer mixer with:
  - configurable layer count and widths;
  - a selectable tie-break rule;
  - a backdrop colour;
  - a defined result when pixel strobes arrive too close together.

Parameters:
LAYERS, 5, number of colour layers (2..8).
CW, 8, colour index width per layer.
PW, 6, priority width; lower value = front.
HW, 3, palette high bits prepended per layer from MMR (OW = CW+HW).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pxl_cen  in  1  pixel clock enable; samples inputs and commits the previous result
cs  in  1  MMR write strobe
addr  in  5  MMR address
din  in  8  MMR write data
pri_in  in  LAYERS*PW  external priority per layer; layer i at bits [i*PW +: PW]
col_in  in  LAYERS*CW  colour index per layer, same packing
shd_in  in  2  shadow code from sprite layer
ioctl_addr  in  5  MMR dump address
ioctl_din  out  8  MMR dump data, combinational
cout  out  OW  palette address of winning layer
col_n  out  1  1 = no opaque layer won
brit  out  1  bright flag
shd_out  out  2  shadow code; 2'b11 = no shadow

Behaviour:
MMR map (8-bit registers):
- 0-7: static priority, layer i.
- 8-15: high bits, layer i.
- 16: EXTEN mask. Bit i=1 uses pri_in for layer i; bit i=0 uses the static register.
- 17: FULL mask. Bit i=1 treats layer i as transparent only when col[7:0]==0; bit i=0 when col[3:0]==0.
- 18: brightness threshold.
- 19-21: shadow thresholds for shd_in 1..3.
- 22: control.
  - bit0 TIE: 0 = lower index wins equal priority; 1 = higher index wins.
  - bit1 BKEN: backdrop enable.
- 23: backdrop colour (low 8 bits of cout, high bits 0).
- Registers for layers >= LAYERS and addresses 24-31 read back 0 and ignore writes.
- Writes take effect on the next clk.
- All MMRs reset to 0.

On pxl_cen (stage 0):
- Latch col_in and shd_in.
- Compute effective priority per layer: all-ones if transparent, else static or external priority per EXTEN.
- Latch per-layer transparency flags.
- Clear step counter st to 1.

Fold steps:
- st=1: best = layer 0.
- st=k, for k = 2..LAYERS: layer k-1 replaces best if its priority < best priority (TIE=0) or <= best priority (TIE=1).
- Each replacement carries {high bits, colour}, the priority and the transparency flag.

Commit step, st = LAYERS+1:
- thr = all-ones if shd_l==0, else MMR[18+shd_l].
- Compute:
  - shd_sel = best_pri < thr
  - brt = best_pri >= MMR[18]
  - tr = best transparency
- If tr and BKEN: the colour becomes the backdrop.
- Copy the result into done registers. The counter then idles (no wrap).

Outputs register on the next pxl_cen, from the done registers:
- cout, col_n = tr, brit = brt.
- shd_out = shd_sel ? ~shd_l : 2'b11.
- Latency is exactly one pixel: inputs sampled at pxl_cen n appear after pxl_cen n+1.
- Minimum pxl_cen spacing is LAYERS+2 clocks.
- If pxl_cen arrives before the commit step, the pipeline restarts and the outputs reload the last completed result (the previous pixel repeats). A partial fold is never output.

pxl_cen and commit in the same clk: pxl_cen wins; the outputs take the old done value, then the pipeline restarts.

Reset mid-pipeline:
- Clears st, done registers and outputs to 0.
- Exception: shd_out resets to 2'b11.

Priority comparisons are unsigned, PW bits wide.

Test Plan:
- LAYERS=5, all static priorities 0x20, TIE=0, all colours opaque (0x11) -> cout = layer 0 colour with MMR[8] high bits, col_n=0; set TIE=1 -> layer 4 wins.
- Static priorities {0x30,0x10,0x20,0x3F,0x3F}, layer 1 colour 0x05, FULL=0 -> cout={MMR[9][2:0],0x05}; set layer 1 colour 0x50 -> layer 1 transparent, layer 2 wins; set FULL bit1 -> layer 1 opaque again.
- All layers transparent, BKEN=1, MMR[23]=0x7E -> cout=0x07E, col_n=1; BKEN=0 -> col_n=1, cout from layer 0.
- Winner priority 0x10, shd_in=2, MMR[20]=0x18 -> shd_out=2'b01; MMR[20]=0x08 -> shd_out=2'b11. MMR[18]=0x10 -> brit=1; MMR[18]=0x11 -> brit=0.
- pxl_cen every 3 clocks with LAYERS=5 -> outputs repeat the last fully committed pixel and never show a partial winner; restore 8-clock spacing -> correct results after one pixel.
- Assert rst_n low at st=3 -> all outputs 0, shd_out=2'b11, MMR readback 0 via ioctl_din; first pixel after release appears after the second pxl_cen.
